// File: rtl/dual_port_register_file_8x4.sv
// 8-entry x 4-bit register file: one synchronous write port, two combinational read ports.
// Define REGFILE_WR_BYPASS_EN to forward same-cycle write data to matching read ports.
module dual_port_register_file_8x4 #(
   parameter int DATA_WIDTH = 4,
   parameter int ADDR_WIDTH = 3,
   parameter int DEPTH      = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_WIDTH-1:0] rd_addr_a,
   input  logic [ADDR_WIDTH-1:0] rd_addr_b,
   output logic [DATA_WIDTH-1:0] rd_data_a,
   output logic [DATA_WIDTH-1:0] rd_data_b
);

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];
   logic                  bypass_a_s;
   logic                  bypass_b_s;

   // Storage update: reset clears every entry and wins over a concurrent write.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else if (wr_en) begin
         mem_r[wr_addr] <= wr_data;
      end
   end

`ifdef REGFILE_WR_BYPASS_EN
   // A write in flight is visible on a matching read port before the edge.
   assign bypass_a_s = wr_en && !rst && (rd_addr_a == wr_addr);
   assign bypass_b_s = wr_en && !rst && (rd_addr_b == wr_addr);
`else
   assign bypass_a_s = 1'b0;
   assign bypass_b_s = 1'b0;
`endif

   // Zero-latency read muxes, one per port.
   always_comb begin
      if (bypass_a_s) begin
         rd_data_a = wr_data;
      end else begin
         rd_data_a = mem_r[rd_addr_a];
      end
      if (bypass_b_s) begin
         rd_data_b = wr_data;
      end else begin
         rd_data_b = mem_r[rd_addr_b];
      end
   end

endmodule

// File: tb/tb_dual_port_register_file_8x4.sv
// Scoreboard bench for dual_port_register_file_8x4: directed plan plus random traffic
// against an array reference model; honours REGFILE_WR_BYPASS_EN.
module tb_dual_port_register_file_8x4;

`ifdef REGFILE_WR_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic       clk;
   logic       rst;
   logic       wr_en;
   logic [2:0] wr_addr;
   logic [3:0] wr_data;
   logic [2:0] rd_addr_a;
   logic [2:0] rd_addr_b;
   logic [3:0] rd_data_a;
   logic [3:0] rd_data_b;

   typedef struct {
      bit         chk;
      logic [3:0] a;
      logic [3:0] b;
      string      name;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       cur;
   logic [3:0] model [8];
   int         compared;
   int         mismatched;

   dual_port_register_file_8x4 dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_addr_a (rd_addr_a),
      .rd_addr_b (rd_addr_b),
      .rd_data_a (rd_data_a),
      .rd_data_b (rd_data_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected read value: stored contents, or the in-flight write when forwarding applies.
   function automatic logic [3:0] exp_rd(input logic [2:0] addr);
      if (BYPASS && wr_en && !rst && (addr == wr_addr))
         return wr_data;
      return model[addr];
   endfunction

   // Called just after a rising edge: drive one cycle, log the expectation, advance the model.
   task automatic cycle(input bit r, input bit we, input logic [2:0] wa, input logic [3:0] wd,
                        input logic [2:0] ra, input logic [2:0] rb, input bit chk, input string name);
      exp_t e;
      rst = r; wr_en = we; wr_addr = wa; wr_data = wd; rd_addr_a = ra; rd_addr_b = rb;
      e.chk = chk; e.a = exp_rd(ra); e.b = exp_rd(rb); e.name = name;
      exp_q.push_back(e);
      @(posedge clk);
      if (r) begin
         for (int i = 0; i < 8; i++) model[i] = 4'h0;
      end else if (we) begin
         model[wa] = wd;
      end
      #1;
   endtask

   // Monitor: compare both read ports against the oldest expectation mid-cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         cur = exp_q.pop_front();
         if (cur.chk) begin
            compared++;
            if (rd_data_a !== cur.a) begin
               mismatched++;
               $display("FAIL %s port A: got %h expected %h", cur.name, rd_data_a, cur.a);
            end
            compared++;
            if (rd_data_b !== cur.b) begin
               mismatched++;
               $display("FAIL %s port B: got %h expected %h", cur.name, rd_data_b, cur.b);
            end
         end
      end
   end

   initial begin
      compared = 0;
      mismatched = 0;
      for (int i = 0; i < 8; i++) model[i] = 4'h0;
      rst = 1'b1; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 4'h0;
      rd_addr_a = 3'd0; rd_addr_b = 3'd0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 8; i++)
         cycle(1'b0, 1'b0, 3'd0, 4'h0, 3'(i), 3'(7 - i), 1'b1, "reset_sweep");

      for (int i = 0; i < 8; i++)
         cycle(1'b0, 1'b1, 3'(i), 4'(i + 1), 3'($urandom_range(0, 7)), 3'(i), 1'b1, "fill");
      for (int i = 0; i < 8; i++)
         cycle(1'b0, 1'b0, 3'd0, 4'h0, 3'(i), 3'(i), 1'b1, "fill_sweep");

      cycle(1'b0, 1'b0, 3'd0, 4'h0, 3'd2, 3'd5, 1'b1, "dual_read");

      cycle(1'b0, 1'b1, 3'd3, 4'hF, 3'd3, 3'd3, 1'b1, "same_addr_before");
      cycle(1'b0, 1'b0, 3'd0, 4'h0, 3'd3, 3'd3, 1'b1, "same_addr_after");

      cycle(1'b0, 1'b0, 3'd0, 4'h0, 3'd0, 3'd7, 1'b1, "boundary");
      cycle(1'b0, 1'b0, 3'd7, 4'h9, 3'd0, 3'd7, 1'b1, "boundary_we0");
      cycle(1'b0, 1'b0, 3'd0, 4'h0, 3'd0, 3'd7, 1'b1, "boundary_hold");

      cycle(1'b1, 1'b1, 3'd4, 4'hA, 3'd4, 3'd0, 1'b1, "rst_prio_before");
      for (int i = 0; i < 8; i++)
         cycle(1'b0, 1'b0, 3'd0, 4'h0, 3'(i), 3'd4, 1'b1, "rst_prio_after");

      for (int n = 0; n < 400; n++)
         cycle(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
               4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
               1'b1, "random");

      @(negedge clk);
      if (exp_q.size() != 0) begin
         mismatched++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/dual_port_register_file_8x4.md
Name: dual_port_register_file_8x4

Overview:
- Register file with 8 entries x 4 bits, one synchronous write port and two independent asynchronous (combinational) read ports A and B.
- Used as a small scratch/operand store in datapath blocks where two operands are read and one result is written per cycle.
- All entries clear on reset.

Parameters:
- DATA_WIDTH, 4, bits per entry.
- ADDR_WIDTH, 3, address bits.
- DEPTH, 8, number of entries; must equal 2**ADDR_WIDTH.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous reset, active-high. Sampled on the rising edge of clk.
- wr_en  input  1  write enable.
- wr_addr  input  ADDR_WIDTH  write address.
- wr_data  input  DATA_WIDTH  write data.
- rd_addr_a  input  ADDR_WIDTH  read address, port A.
- rd_addr_b  input  ADDR_WIDTH  read address, port B.
- rd_data_a  output  DATA_WIDTH  read data, port A.
- rd_data_b  output  DATA_WIDTH  read data, port B.

Behaviour:
- Storage is DEPTH registers of DATA_WIDTH bits each.
- Reset:
  - On a rising clk edge with rst=1, every entry becomes 0.
  - Reset has priority over a concurrent write; the write is dropped.
  - Reset mid-operation discards all contents on that edge.
- Write:
  - On a rising clk edge with rst=0 and wr_en=1, mem[wr_addr] takes wr_data.
  - The written value is visible on the read ports from that edge onward (1-edge latency).
  - wr_en=0 leaves all contents unchanged.
- Read:
  - rd_data_a = mem[rd_addr_a] and rd_data_b = mem[rd_addr_b], purely combinational with zero cycle latency.
  - Outputs follow address changes within the same cycle; no read enable.
- Both ports may address the same entry at once; both return identical data.
- Read/write same address in the same cycle (base build): the read returns the old value until the write edge, then the new value.
- All addresses 0..DEPTH-1 are valid; with DEPTH=2**ADDR_WIDTH there is no out-of-range case and no wrap logic.
- After reset, before any write, every read returns 0.
- Outputs are never X once rst has been applied for one edge.

Optional Feature:
- Macro: REGFILE_WR_BYPASS_EN.
- Defined: write-to-read forwarding. In any cycle with wr_en=1, rst=0 and rd_addr_x==wr_addr, rd_data_x returns wr_data combinationally in the same cycle, before the edge. This applies independently per port.
- Not defined: no forwarding. Reads always return the stored array contents.
- The storage update timing is identical in both builds.

Test Plan:
- Reset check: rst=1 for 1 edge, then rst=0. Sweep rd_addr_a 0..7 -> rd_data_a=0 for every address.
- Fill: write addr i with data i+1 for i=0..7, one write per edge. Sweep port A 0..7 -> i+1; sweep port B 0..7 -> i+1.
- Dual read: rd_addr_a=2, rd_addr_b=5 -> rd_data_a=3 and rd_data_b=6 in the same cycle.
- Same-address write: both ports at addr 3, write 4'hF to addr 3.
  - After the edge: both ports read 4'hF.
  - Before the edge: both read 4 in the base build, 4'hF with REGFILE_WR_BYPASS_EN.
- Boundary: rd_addr_a=0, rd_addr_b=7 -> 1 and 8. Then write 4'h9 to addr 7 with wr_en=0 -> port B still reads 8.
- Reset priority: rst=1 and wr_en=1 (addr 4, data 4'hA) on the same edge -> all entries 0, addr 4 reads 0.
